// File: rtl/next_audio_sample_buffer_pkg.sv
// Shared widths and limits for the NeXT sound-out sample buffer.
// Samples are 32-bit L16:R16 words built from four big-endian bytes.
package next_audio_pkg;

    localparam int SAMPLE_W         = 32;
    localparam int BYTE_W           = 8;
    localparam int BYTES_PER_SAMPLE = 4;
    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

endpackage

// File: rtl/next_audio_sample_buffer_fifo.sv
// Single-clock word FIFO with flush; level counter drives full/empty.
// Read data is registered: a pop shows rd_vld/rd_dat one cycle later; pushes into a full FIFO are refused unless a pop frees the slot.
module audio_word_fifo
    import next_audio_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic                in_clk,
    input  logic                rst,
    input  logic                push_vld,
    input  logic [SAMPLE_W-1:0] push_dat,
    input  logic                pop_req,
    input  logic                flush,
    output logic                push_acc,
    output logic [LW-1:0]       level,
    output logic                rd_vld,
    output logic [SAMPLE_W-1:0] rd_dat
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                rd_vld_q, rd_vld_d;
    logic [SAMPLE_W-1:0] rd_dat_q, rd_dat_d;
    logic                do_pop, do_push;

    always_comb begin
        do_pop   = pop_req && (level_q != '0) && !flush;
        do_push  = push_vld && ((level_q != FULL_LVL) || do_pop) && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_vld_d = do_pop;
        rd_dat_d = rd_dat_q;
        level_d  = level_q;
        if (do_pop) begin
            rd_dat_d = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // When full, push and pop share the head slot; the read uses the old contents.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign push_acc = do_push;
    assign level    = level_q;
    assign rd_vld   = rd_vld_q;
    assign rd_dat   = rd_dat_q;

endmodule

// File: rtl/next_audio_sample_buffer.sv
// Packs NeXT sound-out bytes into L16:R16 words, buffers them and hands one per sender tick.
// Pop-to-out_valid latency is 1 cycle; no backpressure upstream, so words arriving at a full FIFO are dropped and flagged.
module next_audio_sample_buffer
    import next_audio_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LOW_WATER = 1
) (
    input  logic                      in_clk,
    input  logic                      rst,
    input  logic                      byte_valid,
    input  logic [BYTE_W-1:0]         byte_data,
    input  logic                      frame_start,
    input  logic                      cmd_start,
    input  logic                      cmd_end,
    input  logic                      cmd_22k,
    input  logic                      req_tick,
    input  logic                      req_mode,
    output logic                      out_valid,
    output logic [SAMPLE_W-1:0]       out_data,
    output logic                      audio_start_out,
    output logic                      audio_end_out,
    output logic                      audio_22k_out,
    output logic                      host_req,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                underrun_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_SAMPLE - 1);

    logic [1:0]          idx_q, idx_d;
    logic [SAMPLE_W-1:0] word_q, word_d;
    logic                playing_q, playing_d;
    logic                rate_q, rate_d;
    logic                start_pls_q, start_pls_d;
    logic                end_pls_q, end_pls_d;
    logic                host_req_q, host_req_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          underrun_q, underrun_d;

    logic [1:0]          cur_idx;
    logic                push_req, push_acc, tick_live, start_eff;
    logic [LW-1:0]       fifo_level;

    always_comb begin
        cur_idx  = frame_start ? 2'd0 : idx_q;
        word_d   = word_q;
        idx_d    = idx_q;
        push_req = 1'b0;
        if (byte_valid) begin
            word_d[(BYTES_PER_SAMPLE - 1 - int'(cur_idx)) * BYTE_W +: BYTE_W] = byte_data;
            idx_d    = cur_idx + 2'd1;
            push_req = (cur_idx == LAST_IDX);
        end
        if (cmd_end) idx_d = 2'd0;
    end

    always_comb begin
        tick_live   = req_tick && req_mode && playing_q;
        start_eff   = cmd_start && !cmd_end;
        start_pls_d = start_eff;
        end_pls_d   = cmd_end;
        playing_d   = cmd_end ? 1'b0 : (cmd_start ? 1'b1 : playing_q);
        rate_d      = (cmd_start || cmd_end) ? cmd_22k : rate_q;
        host_req_d  = playing_q && (fifo_level <= LW'(LOW_WATER));

        underrun_d = underrun_q;
        if (start_eff) underrun_d = 8'd0;
        else if (tick_live && (fifo_level == '0) && (underrun_q != UNDERRUN_MAX))
            underrun_d = underrun_q + 8'd1;

        // A refused word sets the flag even in the cycle a start clears it.
        overflow_d = start_eff ? 1'b0 : overflow_q;
        if (push_req && !push_acc && !cmd_end) overflow_d = 1'b1;
    end

    audio_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .in_clk   (in_clk),
        .rst      (rst),
        .push_vld (push_req),
        .push_dat (word_d),
        .pop_req  (tick_live),
        .flush    (cmd_end),
        .push_acc (push_acc),
        .level    (fifo_level),
        .rd_vld   (out_valid),
        .rd_dat   (out_data)
    );

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 2'd0;
            word_q      <= '0;
            playing_q   <= 1'b0;
            rate_q      <= 1'b0;
            start_pls_q <= 1'b0;
            end_pls_q   <= 1'b0;
            host_req_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 8'd0;
        end else begin
            idx_q       <= idx_d;
            word_q      <= word_d;
            playing_q   <= playing_d;
            rate_q      <= rate_d;
            start_pls_q <= start_pls_d;
            end_pls_q   <= end_pls_d;
            host_req_q  <= host_req_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    assign audio_start_out = start_pls_q;
    assign audio_end_out   = end_pls_q;
    assign audio_22k_out   = rate_q;
    assign host_req        = host_req_q;
    assign level           = fifo_level;
    assign overflow        = overflow_q;
    assign underrun_cnt    = underrun_q;

endmodule

// File: tb/tb_next_audio_sample_buffer.sv
// Randomised and directed bench for next_audio_sample_buffer with a queue-based reference model.
// The driver updates the model at each active edge; a negedge monitor compares every output.
module tb_next_audio_sample_buffer;

    localparam int DEPTH     = 4;
    localparam int LOW_WATER = 1;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic          in_clk = 1'b0;
    logic          rst = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          frame_start = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_end = 1'b0;
    logic          cmd_22k = 1'b0;
    logic          req_tick = 1'b0;
    logic          req_mode = 1'b1;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          audio_start_out, audio_end_out, audio_22k_out, host_req, overflow;
    logic [LW-1:0] level;
    logic [7:0]    underrun_cnt;

    next_audio_sample_buffer #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
        .in_clk(in_clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_start(frame_start), .cmd_start(cmd_start), .cmd_end(cmd_end),
        .cmd_22k(cmd_22k), .req_tick(req_tick), .req_mode(req_mode),
        .out_valid(out_valid), .out_data(out_data), .audio_start_out(audio_start_out),
        .audio_end_out(audio_end_out), .audio_22k_out(audio_22k_out), .host_req(host_req),
        .level(level), .overflow(overflow), .underrun_cnt(underrun_cnt)
    );

    always #5 in_clk = ~in_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  m_bytes[4];
    int          m_idx, m_under;
    bit          m_playing, m_22k, m_ov, m_start, m_end, m_host;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_idx = 0; m_under = 0;
        m_playing = 0; m_22k = 0; m_ov = 0; m_start = 0; m_end = 0; m_host = 0;
    endtask

    task automatic model_step();
        int          sz = m_q.size();
        bit          tk = req_tick && req_mode && m_playing;
        bit          have_word = 0;
        int          k;
        logic [31:0] w = '0;
        m_host  = m_playing && (sz <= LOW_WATER);
        m_start = cmd_start && !cmd_end;
        m_end   = cmd_end;
        if (tk && sz == 0 && m_under < 255) m_under++;
        if (byte_valid) begin
            k = frame_start ? 0 : m_idx;
            m_bytes[k] = byte_data;
            m_idx = (k + 1) % 4;
            if (k == 3) begin
                have_word = 1;
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            end
        end
        if (cmd_end) begin
            m_q.delete();
            m_idx = 0;
            m_playing = 0;
            m_22k = cmd_22k;
        end else begin
            if (cmd_start) begin
                m_playing = 1;
                m_22k = cmd_22k;
                m_ov = 0;
                m_under = 0;
            end
            if (tk && sz > 0) exp_q.push_back(m_q.pop_front());
            if (have_word) begin
                if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ov = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        model_step();
        #1;
        byte_valid = 0; frame_start = 0; cmd_start = 0; cmd_end = 0; req_tick = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fs);
        byte_valid = 1; byte_data = b; frame_start = fs;
        step();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31 - 8 * i -: 8], i == 0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            req_tick = 1;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #1;
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge in_clk);
        #1 rst = 0;
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge in_clk);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
            exp_q.delete();
            chk("level", level, m_q.size());
            chk("overflow", overflow, m_ov);
            chk("underrun_cnt", underrun_cnt, m_under);
            chk("audio_22k_out", audio_22k_out, m_22k);
            chk("audio_start_out", audio_start_out, m_start);
            chk("audio_end_out", audio_end_out, m_end);
            chk("host_req", host_req, m_host);
        end
    end

    initial begin
        logic [31:0] first_w;
        model_reset();
        #1;
        do_reset();

        // Start at 22.05 kHz
        cmd_22k = 1; cmd_start = 1;
        step();
        @(negedge in_clk);
        chk("t1_start_pulse", audio_start_out, 1);
        chk("t1_rate", audio_22k_out, 1);
        step();
        @(negedge in_clk);
        chk("t1_start_pulse_gone", audio_start_out, 0);
        chk("t1_host_req", host_req, 1);

        // Basic word assembly and pop
        send_byte(8'h12, 1); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        tick(1);
        @(negedge in_clk);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 32'h12345678);
        chk("t2_level", level, 0);

        // Overflow with five words into four slots
        for (int i = 0; i < 5; i++) send_word(32'hC0DE0000 + i);
        step();
        @(negedge in_clk);
        chk("t3_level_full", level, 4);
        chk("t3_overflow", overflow, 1);
        tick(4);
        tick(1);
        @(negedge in_clk);
        chk("t3_underrun", underrun_cnt, 1);
        chk("t3_no_valid", out_valid, 0);

        // Push and pop together while full
        cmd_start = 1;
        step();
        first_w = 32'hA0000001;
        for (int i = 0; i < 4; i++) send_word(32'hA0000001 + i);
        send_byte(8'hB1, 1); send_byte(8'hB2, 0); send_byte(8'hB3, 0);
        byte_valid = 1; byte_data = 8'hB4; req_tick = 1;
        step();
        @(negedge in_clk);
        chk("t4_level", level, 4);
        chk("t4_overflow", overflow, 0);
        chk("t4_oldest", out_data, first_w);
        tick(4);

        // Realignment on frame_start
        send_byte(8'hAA, 1); send_byte(8'hBB, 0);
        send_byte(8'h11, 1); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        tick(1);
        @(negedge in_clk);
        chk("t5_realign", out_data, 32'h11223344);

        // Underrun saturation, then start+end together
        tick(300);
        @(negedge in_clk);
        chk("t6_saturate", underrun_cnt, 255);
        cmd_22k = 0; cmd_start = 1; cmd_end = 1;
        step();
        @(negedge in_clk);
        chk("t6_end_pulse", audio_end_out, 1);
        chk("t6_no_start", audio_start_out, 0);
        chk("t6_level", level, 0);
        tick(5);
        @(negedge in_clk);
        chk("t6_still_255", underrun_cnt, 255);
        chk("t6_host_req", host_req, 0);

        // Asynchronous reset mid-word with data buffered
        cmd_start = 1;
        step();
        send_word(32'hDEADBEEF);
        send_byte(8'h01, 1); send_byte(8'h02, 0);
        #2;
        do_reset();
        send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h05, 0); send_byte(8'h06, 0);
        @(negedge in_clk);
        chk("rst_idx_cleared", level, 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            byte_valid  = ($urandom_range(0, 2) != 0);
            byte_data   = 8'($urandom);
            frame_start = byte_valid && ($urandom_range(0, 15) == 0);
            req_tick    = ($urandom_range(0, 3) == 0);
            req_mode    = ($urandom_range(0, 7) != 0);
            cmd_start   = ($urandom_range(0, 99) == 0);
            cmd_end     = ($urandom_range(0, 149) == 0);
            cmd_22k     = 1'($urandom);
            step();
        end
        req_mode = 1;
        step();
        @(negedge in_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
